// File: rtl/poly_osc.sv
// rtl/poly_osc.sv - multi-channel square/pulse oscillator with registered voice-count mix
// Define POLY_OSC_SHADOW_EN to sample period/duty only at start, wrap or sync (glitch-free).
module poly_osc #(
    parameter int NCH     = 4,
    parameter int CNT_BW  = 16,
    parameter int DUTY_BW = 8
) (
    input  logic                     clk_i,
    input  logic                     nrst_i,
    input  logic [NCH-1:0]           enable_i,
    input  logic [NCH*CNT_BW-1:0]    period_i,
    input  logic [NCH*DUTY_BW-1:0]   duty_i,
    input  logic                     sync_i,
    output logic [NCH-1:0]           wave_o,
    output logic [$clog2(NCH+1)-1:0] mix_o
);
    localparam int MIX_BW  = $clog2(NCH+1);
    localparam int PROD_BW = CNT_BW + DUTY_BW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CNT_BW-1:0]  p_in;
        logic [DUTY_BW-1:0] d_in;
        logic [PROD_BW-1:0] prod;
        logic [CNT_BW-1:0]  t_in;
        logic [CNT_BW-1:0]  ta;
        logic [CNT_BW-1:0]  cnt_q;
        logic [CNT_BW-1:0]  cnt_d;
        logic [CNT_BW-1:0]  cnt_inc;
        logic               wave_q;
        logic               wave_d;
        logic               wrap;
        logic               restart;
        state_t             state_q;
        state_t             state_d;

        assign p_in    = period_i[c*CNT_BW +: CNT_BW];
        assign d_in    = duty_i[c*DUTY_BW +: DUTY_BW];
        assign prod    = PROD_BW'(p_in) * PROD_BW'(d_in);
        assign t_in    = prod[PROD_BW-1:DUTY_BW];
        assign cnt_inc = cnt_q + CNT_BW'(1);

`ifdef POLY_OSC_SHADOW_EN
        logic [CNT_BW-1:0] pa_q;
        logic [CNT_BW-1:0] ta_q;

        // A degenerate active period wraps every edge so a valid new period is picked up at once.
        assign wrap = (pa_q < CNT_BW'(2)) || (cnt_q == pa_q - CNT_BW'(1));
        assign ta   = ta_q;

        always_ff @(posedge clk_i or negedge nrst_i) begin
            if (!nrst_i) begin
                pa_q <= '0;
                ta_q <= '0;
            end else if (enable_i[c] && restart) begin
                pa_q <= p_in;
                ta_q <= t_in;
            end
        end
`else
        // Live tracking: shrinking the period below the current count wraps on the next edge.
        assign wrap = (p_in < CNT_BW'(2)) || (cnt_q >= p_in - CNT_BW'(1));
        assign ta   = t_in;
`endif

        assign restart = (state_q == ST_IDLE) || sync_i || wrap;

        always_ff @(posedge clk_i or negedge nrst_i) begin
            if (!nrst_i) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: if (enable_i[c]) state_d = ST_RUN;
                ST_RUN:  if (!enable_i[c]) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        always_comb begin
            cnt_d  = '0;
            wave_d = 1'b0;
            if (enable_i[c]) begin
                if (restart) begin
                    cnt_d  = '0;
                    wave_d = (t_in != '0);
                end else begin
                    cnt_d  = cnt_inc;
                    wave_d = (cnt_inc < ta);
                end
            end
        end

        always_ff @(posedge clk_i or negedge nrst_i) begin
            if (!nrst_i) begin
                cnt_q  <= '0;
                wave_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                wave_q <= wave_d;
            end
        end

        assign wave_o[c] = wave_q;
    end

    logic [MIX_BW-1:0] pop;

    always_comb begin
        pop = '0;
        for (int c = 0; c < NCH; c++) begin
            pop = pop + MIX_BW'(wave_o[c]);
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            mix_o <= '0;
        end else begin
            mix_o <= pop;
        end
    end
endmodule
